// File: rtl/seg7_decoder.sv
// Registered 7-segment glyph decoder for one display digit.
// Lamp test overrides blank, and blank overrides the digit code. The output is cleared to blank on reset.
module seg7_decoder #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] value,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] hex
);

  localparam logic [6:0] ALL_OFF_AL = 7'h7F;
  localparam logic [6:0] ALL_ON_AL  = 7'h00;

  logic [6:0] w_next_al;
  logic [6:0] r_hex;

  // Glyph table in active-low gfedcba order (bit 0 = segment a).
  function automatic logic [6:0] glyph_al(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      5'd0:    pat = 7'h40;
      5'd1:    pat = 7'h79;
      5'd2:    pat = 7'h24;
      5'd3:    pat = 7'h30;
      5'd4:    pat = 7'h19;
      5'd5:    pat = 7'h12;
      5'd6:    pat = 7'h02;
      5'd7:    pat = 7'h78;
      5'd8:    pat = 7'h00;
      5'd9:    pat = 7'h10;
      5'd10:   pat = 7'h08;
      5'd11:   pat = 7'h03;
      5'd12:   pat = 7'h46;
      5'd13:   pat = 7'h21;
      5'd14:   pat = 7'h06;
      5'd15:   pat = 7'h0E;
      5'd16:   pat = 7'h3F;
      default: pat = ALL_OFF_AL;
    endcase
    return pat;
  endfunction

  function automatic logic [6:0] to_board(input logic [6:0] pat_al);
    return ACTIVE_LOW ? pat_al : ~pat_al;
  endfunction

  always_comb begin
    w_next_al = glyph_al(value);
    if (lamp_test)
      w_next_al = ALL_ON_AL;
    else if (blank)
      w_next_al = ALL_OFF_AL;
  end

  // Output register: all digit instances update together on this edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      r_hex <= to_board(ALL_OFF_AL);
    else
      r_hex <= to_board(w_next_al);
  end

  assign hex = r_hex;

endmodule

// File: tb/tb_seg7_decoder.sv
// Bench for seg7_decoder: both output polarities are driven from shared inputs.
// The driver queues the expected pattern, and a monitor compares it one edge later.
module tb_seg7_decoder;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [4:0] value;
  logic       blank;
  logic       lamp_test;
  logic [6:0] hex_al;
  logic [6:0] hex_ah;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_q[$];

  seg7_decoder #(.ACTIVE_LOW(1'b1)) dut_al (
    .Clock(Clock), .Reset(Reset), .value(value), .blank(blank),
    .lamp_test(lamp_test), .hex(hex_al)
  );

  seg7_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (
    .Clock(Clock), .Reset(Reset), .value(value), .blank(blank),
    .lamp_test(lamp_test), .hex(hex_ah)
  );

  always #5 Clock = ~Clock;

  // Lit segments per glyph, written as segment letters; index 16 is the minus sign.
  string LIT [17] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg",
                      "aefg", "g"};

  function automatic logic [6:0] model_al(input logic [4:0] v, input logic b, input logic lt);
    logic [6:0] pat;
    string s;
    if (lt) return 7'h00;
    if (b) return 7'h7F;
    if (v > 5'd16) return 7'h7F;
    s = LIT[v];
    pat = 7'h7F;
    for (int i = 0; i < s.len(); i++) begin
      int idx;
      idx = int'(s[i]) - 97;
      pat[idx] = 1'b0;
    end
    return pat;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 7'h%02h expected 7'h%02h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one input set at the falling edge and queue its expected response.
  task automatic step(input logic [4:0] v, input logic b, input logic lt);
    value = v;
    blank = b;
    lamp_test = lt;
    exp_q.push_back(model_al(v, b, lt));
    @(negedge Clock);
  endtask

  initial begin : monitor
    logic [6:0] e;
    forever begin
      @(posedge Clock);
      #1;
      if (!Reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("decode_al", hex_al, e);
        check("decode_ah", hex_ah, ~e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : driver
    Reset = 1'b1;
    value = 5'd8;
    blank = 1'b0;
    lamp_test = 1'b0;
    #1;
    check("reset_before_edge_al", hex_al, 7'h7F);
    check("reset_before_edge_ah", hex_ah, 7'h00);

    @(negedge Clock);
    @(negedge Clock);
    check("reset_held_al", hex_al, 7'h7F);
    Reset = 1'b0;
    step(5'd8, 1'b0, 1'b0);

    for (int v = 0; v < 32; v++)
      step(5'(v), 1'b0, 1'b0);

    step(5'd7, 1'b0, 1'b0);
    step(5'd7, 1'b1, 1'b0);
    step(5'd7, 1'b0, 1'b0);
    step(5'd7, 1'b0, 1'b0);

    step(5'd1, 1'b1, 1'b1);
    step(5'd1, 1'b1, 1'b0);
    step(5'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges while a digit is showing.
    step(5'd9, 1'b0, 1'b0);
    check("pre_async_reset_al", hex_al, 7'h10);
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset_al", hex_al, 7'h7F);
    check("async_reset_ah", hex_ah, 7'h00);
    @(negedge Clock);
    @(negedge Clock);
    check("async_reset_hold_al", hex_al, 7'h7F);
    Reset = 1'b0;
    #1;
    check("no_stale_after_release_al", hex_al, 7'h7F);
    check("no_stale_after_release_ah", hex_ah, 7'h00);
    @(negedge Clock);
    exp_q.delete();

    step(5'd0, 1'b0, 1'b0);
    for (int n = 0; n < 200; n++)
      step(5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0));

    @(posedge Clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
